// File: rtl/irq_priority_arbiter_pkg.sv
// rtl/irq_priority_arbiter_pkg.sv - shared constants, state encoding and priority helper
package irq_priority_arbiter_pkg;

    localparam int N_SRC = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    localparam logic [1:0] SRC_TIMER = 2'd0;
    localparam logic [1:0] SRC_MOUSE = 2'd1;
    localparam logic [1:0] SRC_USER2 = 2'd2;
    localparam logic [1:0] SRC_USER3 = 2'd3;

    // Lowest set index wins; scanning downward lets the last hit be the answer.
    function automatic logic [1:0] prio_sel(input logic [N_SRC-1:0] elig);
        logic [1:0] sel;
        sel = SRC_TIMER;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                sel = i[1:0];
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/irq_edge_detect.sv
// rtl/irq_edge_detect.sv - per-line set pulse generation, rising-edge or level
module irq_edge_detect #(
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [3:0] irq_raw_i,
    output logic [3:0] set_o
);

    logic [3:0] prev_q;

    // prev resets to 0 so a line already high at reset release reads as an edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prev_q <= 4'b0000;
        end else begin
            prev_q <= irq_raw_i;
        end
    end

    assign set_o = EDGE_MODE ? (irq_raw_i & ~prev_q) : irq_raw_i;

endmodule

// File: rtl/irq_priority_arbiter.sv
// rtl/irq_priority_arbiter.sv - pending capture, masked fixed-priority select and req/ack/done FSM
module irq_priority_arbiter
    import irq_priority_arbiter_pkg::*;
#(
    parameter bit EDGE_MODE = 1'b1,
    parameter int N_SRC     = 4
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic [3:0] IRQ_RAW,
    input  logic [3:0] IRQ_MASK,
    input  logic       ACK,
    input  logic       DONE,
    output logic       IRQ_REQ,
    output logic [1:0] IRQ_SEL,
    output logic [3:0] PENDING,
    output logic       IN_SERVICE
);

    if (N_SRC != irq_priority_arbiter_pkg::N_SRC) begin : g_nsrc_check
        $error("irq_priority_arbiter: N_SRC must be 4 to match the 2-bit mux select");
    end

    state_e     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] pending_q, pending_d;
    logic [3:0] set_pulse;
    logic [3:0] clr_vec;
    logic [3:0] elig;

    irq_edge_detect #(
        .EDGE_MODE (EDGE_MODE)
    ) u_edge_detect (
        .clk_i     (CLK),
        .rst_n_i   (RESETN),
        .irq_raw_i (IRQ_RAW),
        .set_o     (set_pulse)
    );

    assign elig = pending_q & IRQ_MASK;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        clr_vec = 4'b0000;
        case (state_q)
            ST_IDLE: begin
                if (|elig) begin
                    sel_d   = prio_sel(elig);
                    state_d = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                if (ACK) begin
                    clr_vec[sel_q] = 1'b1;
                    state_d        = ST_SERVICE;
                end else if (!elig[sel_q]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (DONE) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Set after clear: an edge landing in the ACK cycle is kept.
        pending_d = (pending_q & ~clr_vec) | set_pulse;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q   <= ST_IDLE;
            sel_q     <= 2'b00;
            pending_q <= 4'b0000;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            pending_q <= pending_d;
        end
    end

    assign IRQ_REQ    = (state_q == ST_REQUEST);
    assign IN_SERVICE = (state_q == ST_SERVICE);
    assign IRQ_SEL    = sel_q;
    assign PENDING    = pending_q;

endmodule

// File: tb/tb_irq_priority_arbiter.sv
// tb/tb_irq_priority_arbiter.sv - table-driven scoreboard bench for edge and level arbiters
module tb_irq_priority_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] e_raw, e_mask, l_raw, l_mask;
    logic       e_ack, e_done, l_ack, l_done;
    logic       e_req, l_req, e_svc, l_svc;
    logic [1:0] e_sel, l_sel;
    logic [3:0] e_pend, l_pend;

    always #5 clk = ~clk;

    irq_priority_arbiter #(.EDGE_MODE(1'b1), .N_SRC(4)) u_edge (
        .CLK(clk), .RESETN(rst_n), .IRQ_RAW(e_raw), .IRQ_MASK(e_mask),
        .ACK(e_ack), .DONE(e_done), .IRQ_REQ(e_req), .IRQ_SEL(e_sel),
        .PENDING(e_pend), .IN_SERVICE(e_svc)
    );

    irq_priority_arbiter #(.EDGE_MODE(1'b0), .N_SRC(4)) u_level (
        .CLK(clk), .RESETN(rst_n), .IRQ_RAW(l_raw), .IRQ_MASK(l_mask),
        .ACK(l_ack), .DONE(l_done), .IRQ_REQ(l_req), .IRQ_SEL(l_sel),
        .PENDING(l_pend), .IN_SERVICE(l_svc)
    );

    typedef struct {
        string      name;
        logic [3:0] raw;
        logic [3:0] mask;
        logic       ack;
        logic       done;
        logic       req;
        logic [1:0] sel;
        logic [3:0] pend;
        logic       svc;
    } vec_t;

    vec_t tbl[$];
    vec_t sb_q[$];
    int   passed = 0;
    int   total  = 0;

    function automatic vec_t mk(input string n, input logic [3:0] raw, input logic [3:0] mask,
                                input logic ack, input logic done, input logic req,
                                input logic [1:0] sel, input logic [3:0] pend, input logic svc);
        vec_t v;
        v.name = n; v.raw = raw; v.mask = mask; v.ack = ack; v.done = done;
        v.req = req; v.sel = sel; v.pend = pend; v.svc = svc;
        return v;
    endfunction

    task automatic add(input vec_t v);
        tbl.push_back(v);
    endtask

    // Drive one cycle of stimulus on the chosen DUT, then compare after the edge.
    task automatic run(input bit lvl, input vec_t v);
        vec_t       e;
        logic [7:0] act;
        logic [7:0] exp;
        sb_q.push_back(v);
        if (lvl) begin
            l_raw = v.raw; l_mask = v.mask; l_ack = v.ack; l_done = v.done;
        end else begin
            e_raw = v.raw; e_mask = v.mask; e_ack = v.ack; e_done = v.done;
        end
        @(posedge clk);
        #1;
        e   = sb_q.pop_front();
        exp = {e.req, e.sel, e.pend, e.svc};
        act = lvl ? {l_req, l_sel, l_pend, l_svc} : {e_req, e_sel, e_pend, e_svc};
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got req=%b sel=%0d pend=%b svc=%b, want req=%b sel=%0d pend=%b svc=%b",
                     e.name, act[7], act[6:5], act[4:1], act[0], exp[7], exp[6:5], exp[4:1], exp[0]);
        end
        if (lvl) begin
            l_ack = 1'b0; l_done = 1'b0;
        end else begin
            e_ack = 1'b0; e_done = 1'b0;
        end
    endtask

    task automatic check_zero(input string n);
        logic [15:0] act;
        act = {e_req, e_sel, e_pend, e_svc, l_req, l_sel, l_pend, l_svc};
        total++;
        if (act === 16'h0000) begin
            passed++;
        end else begin
            $display("FAIL %s: got outputs %h, want 0000", n, act);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        e_raw = 4'hF; l_raw = 4'hF; e_mask = 4'hF; l_mask = 4'hF;
        e_ack = 1'b0; e_done = 1'b0; l_ack = 1'b0; l_done = 1'b0;

        //   name          raw    mask   ack   done  req   sel    pend   svc
        add(mk("idle0",    4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0));
        add(mk("idle1",    4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0));
        add(mk("s2_pend",  4'h4, 4'hF, 1'b0, 1'b0, 1'b0, 2'd0, 4'h4, 1'b0));
        add(mk("s2_req",   4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 2'd2, 4'h4, 1'b0));
        add(mk("s2_ack",   4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 2'd2, 4'h0, 1'b1));
        add(mk("s2_svc",   4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 2'd2, 4'h0, 1'b1));
        add(mk("s2_done",  4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 2'd2, 4'h0, 1'b0));
        add(mk("s2_quiet", 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 2'd2, 4'h0, 1'b0));
        add(mk("pr_pend",  4'hA, 4'hF, 1'b0, 1'b0, 1'b0, 2'd2, 4'hA, 1'b0));
        add(mk("pr_req1",  4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 2'd1, 4'hA, 1'b0));
        add(mk("pr_ack1",  4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 2'd1, 4'h8, 1'b1));
        add(mk("pr_done1", 4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 2'd1, 4'h8, 1'b0));
        add(mk("pr_req3",  4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 2'd3, 4'h8, 1'b0));
        add(mk("pr_ack3",  4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 2'd3, 4'h0, 1'b1));
        add(mk("pr_done3", 4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 2'd3, 4'h0, 1'b0));
        add(mk("mk_pend",  4'h1, 4'hF, 1'b0, 1'b0, 1'b0, 2'd3, 4'h1, 1'b0));
        add(mk("mk_req",   4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 2'd0, 4'h1, 1'b0));
        add(mk("mk_drop",  4'h0, 4'hE, 1'b0, 1'b0, 1'b0, 2'd0, 4'h1, 1'b0));
        add(mk("mk_hold",  4'h0, 4'hE, 1'b0, 1'b0, 1'b0, 2'd0, 4'h1, 1'b0));
        add(mk("mk_reen",  4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 2'd0, 4'h1, 1'b0));
        add(mk("mk_ack",   4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 1'b1));
        add(mk("mk_done",  4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0));
        add(mk("rc_pend",  4'h2, 4'hF, 1'b0, 1'b0, 1'b0, 2'd0, 4'h2, 1'b0));
        add(mk("rc_req",   4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 2'd1, 4'h2, 1'b0));
        add(mk("rc_race",  4'h2, 4'hF, 1'b1, 1'b0, 1'b0, 2'd1, 4'h2, 1'b1));
        add(mk("rc_svc",   4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 2'd1, 4'h2, 1'b1));
        add(mk("rc_done",  4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 2'd1, 4'h2, 1'b0));
        add(mk("rc_rereq", 4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 2'd1, 4'h2, 1'b0));
        add(mk("rc_ack2",  4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 2'd1, 4'h0, 1'b1));
        add(mk("rc_done2", 4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 2'd1, 4'h0, 1'b0));
        add(mk("ig_ack",   4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 2'd1, 4'h0, 1'b0));
        add(mk("ig_done",  4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 2'd1, 4'h0, 1'b0));
        add(mk("np_pend",  4'h8, 4'hF, 1'b0, 1'b0, 1'b0, 2'd1, 4'h8, 1'b0));
        add(mk("np_req3",  4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 2'd3, 4'h8, 1'b0));
        add(mk("np_hi",    4'h1, 4'hF, 1'b0, 1'b0, 1'b1, 2'd3, 4'h9, 1'b0));
        add(mk("np_ack3",  4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 2'd3, 4'h1, 1'b1));
        add(mk("np_done3", 4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 2'd3, 4'h1, 1'b0));
        add(mk("np_req0",  4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 2'd0, 4'h1, 1'b0));
        add(mk("np_ack0",  4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 1'b1));
        add(mk("np_done0", 4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0));

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_hold");
        rst_n = 1'b1;
        e_raw = 4'h0;
        l_raw = 4'h0;

        foreach (tbl[i]) run(1'b0, tbl[i]);

        // Level mode: line 0 held high keeps re-setting its pending bit.
        run(1'b1, mk("lv_pend",   4'h1, 4'hF, 1'b0, 1'b0, 1'b0, 2'd0, 4'h1, 1'b0));
        run(1'b1, mk("lv_req",    4'h1, 4'hF, 1'b0, 1'b0, 1'b1, 2'd0, 4'h1, 1'b0));
        run(1'b1, mk("lv_done_x", 4'h1, 4'hF, 1'b0, 1'b1, 1'b1, 2'd0, 4'h1, 1'b0));
        run(1'b1, mk("lv_ack",    4'h1, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0, 4'h1, 1'b1));
        run(1'b1, mk("lv_ack_x",  4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0, 4'h1, 1'b1));
        run(1'b1, mk("lv_done",   4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 2'd0, 4'h1, 1'b0));
        run(1'b1, mk("lv_rereq",  4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 2'd0, 4'h1, 1'b0));
        run(1'b1, mk("lv_ack2",   4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 1'b1));
        run(1'b1, mk("lv_done2",  4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0));
        run(1'b1, mk("lv_quiet",  4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0));

        // Reset asserted mid-cycle while a request is outstanding.
        run(1'b0, mk("mr_pend",   4'h4, 4'hF, 1'b0, 1'b0, 1'b0, 2'd0, 4'h4, 1'b0));
        run(1'b0, mk("mr_req",    4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 2'd2, 4'h4, 1'b0));
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("reset_async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(1'b0, mk("mr_after0", 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0));
        run(1'b0, mk("mr_after1", 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
